// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM state encoding and op-decode helpers shared by
// the multi-cycle multiply/divide sequencer.
// Optional build macro MULDIV_FUSE_EN (result reuse) is handled in muldiv_seq.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Same encoding as alufn[2:0] with alufn[4]=1.
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Signedness classes used in the reuse tag.
  localparam logic [1:0] CLS_SS = 2'd0;
  localparam logic [1:0] CLS_SU = 2'd1;
  localparam logic [1:0] CLS_UU = 2'd2;

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic [1:0] op_cls(input logic [2:0] op);
    if (op_a_signed(op) && op_b_signed(op)) return CLS_SS;
    else if (op_a_signed(op))               return CLS_SU;
    else                                    return CLS_UU;
  endfunction

  // Low half of the result pair: product low word or quotient.
  // High half: product high word or remainder.
  function automatic logic op_pick_lo(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the magnitude datapath.
//   multiply: {hi,lo} holds {partial product, remaining multiplier bits};
//             add opnd when lo[0] is set, then shift the pair right by one.
//   divide:   {hi,lo} holds {partial remainder, remaining dividend bits};
//             shift left, trial-subtract opnd, keep the difference if it fits
//             and shift the quotient bit into lo[0].
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            fits;

  // Shift-add or restore-subtract step selected by is_div_i.
  always_comb begin
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
    shifted = {hi_i, lo_i[XLEN-1]};
    fits    = (shifted >= {1'b0, opnd_i});
    // The true difference is below opnd when it fits, so XLEN bits suffice.
    diff    = shifted[XLEN-1:0] - opnd_i;
    if (is_div_i) begin
      hi_o = fits ? diff : shifted[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], fits};
    end else begin
      hi_o = sum[XLEN:1];
      lo_o = {sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M multiply/divide sequencer.
// Operates on operand magnitudes for XLEN iterations, then one finalize edge
// applies the sign fix-up and result select. Divide-by-zero and signed
// overflow resolve at the accept edge and go straight to DONE.
// Build option: MULDIV_FUSE_EN keeps the last result pair plus an operand tag
// so a matching follow-up (MULH then MUL, DIV then REM) skips iteration.
//
// Handshake: a request transfers on a rising edge where req_valid & req_ready;
// the response transfers on a rising edge where resp_valid & resp_ready.
// resp_valid and resp_result stay stable until taken; flush drops any work,
// including an untaken result, and holds req_ready low while asserted.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            busy,
  output state_e          dbg_state_o
);

  localparam int              CW       = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              negp_q, negp_d;   // negate product / quotient
  logic              negr_q, negr_d;   // negate remainder
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [XLEN-1:0]   pair_hi, pair_lo;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN-1:0]   fuse_hi, fuse_lo;
  logic [2*XLEN-1:0] prod_fix;
  logic              accept, sa, sb, div_zero, div_ovf, fuse_hit;

  assign req_ready   = (state_q == ST_IDLE) & ~flush;
  assign accept      = req_valid & req_ready;
  assign resp_valid  = (state_q == ST_DONE);
  assign resp_result = result_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

  assign sa       = op_a_signed(req_op) & req_a[XLEN-1];
  assign sb       = op_b_signed(req_op) & req_b[XLEN-1];
  assign mag_a    = sa ? -req_a : req_a;
  assign mag_b    = sb ? -req_b : req_b;
  assign div_zero = req_op[2] & (req_b == '0);
  assign div_ovf  = ((req_op == OP_DIV) | (req_op == OP_REM)) &
                    (req_a == MIN_NEG) & (req_b == '1);
  assign prod_fix = negp_q ? -{hi_q, lo_q} : {hi_q, lo_q};

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (state_q == ST_DIV),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .opnd_i   (opnd_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  // Next-state, iteration and finalize logic; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    negp_d   = negp_q;
    negr_d   = negr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    pair_hi  = '0;
    pair_lo  = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d   = req_op;
          negp_d = sa ^ sb;
          negr_d = sa;
          cnt_d  = '0;
          if (div_zero | div_ovf | fuse_hit) begin
            if (div_zero) begin
              pair_hi = req_a;
              pair_lo = '1;
            end else if (div_ovf) begin
              pair_hi = '0;
              pair_lo = MIN_NEG;
            end else begin
              pair_hi = fuse_hi;
              pair_lo = fuse_lo;
            end
            result_d = op_pick_lo(req_op) ? pair_lo : pair_hi;
            state_d  = ST_DONE;
          end else if (req_op[2]) begin
            hi_d    = '0;
            lo_d    = mag_a;
            opnd_d  = mag_b;
            state_d = ST_DIV;
          end else begin
            hi_d    = '0;
            lo_d    = mag_b;
            opnd_d  = mag_a;
            state_d = ST_MUL;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_q != LAST_CNT) begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + CW'(1);
        end else begin
          if (state_q == ST_MUL) begin
            {pair_hi, pair_lo} = prod_fix;
          end else begin
            pair_hi = negr_q ? -hi_q : hi_q;
            pair_lo = negp_q ? -lo_q : lo_q;
          end
          result_d = op_pick_lo(op_q) ? pair_lo : pair_hi;
          cnt_d    = '0;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  // State, counter and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      negp_q   <= 1'b0;
      negr_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      negp_q   <= negp_d;
      negr_q   <= negr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
    end
  end

`ifdef MULDIV_FUSE_EN
  logic            tag_valid_q;
  logic [XLEN-1:0] tag_a_q, tag_b_q;
  logic [XLEN-1:0] tag_hi_q, tag_lo_q;
  logic [1:0]      tag_cls_q;
  logic            tag_div_q;
  logic            enter_done;

  assign enter_done = (state_q != ST_DONE) & (state_d == ST_DONE);
  assign fuse_hit   = tag_valid_q & (tag_a_q == req_a) & (tag_b_q == req_b) &
                      (tag_cls_q == op_cls(req_op)) & (tag_div_q == req_op[2]);
  assign fuse_hi    = tag_hi_q;
  assign fuse_lo    = tag_lo_q;

  // Tag fields are captured at accept; the tag becomes valid only once the
  // result pair lands, so a flushed or reset operation never leaves a tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid_q <= 1'b0;
      tag_a_q     <= '0;
      tag_b_q     <= '0;
      tag_cls_q   <= CLS_SS;
      tag_div_q   <= 1'b0;
      tag_hi_q    <= '0;
      tag_lo_q    <= '0;
    end else if (flush) begin
      tag_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        tag_a_q     <= req_a;
        tag_b_q     <= req_b;
        tag_cls_q   <= op_cls(req_op);
        tag_div_q   <= req_op[2];
        tag_valid_q <= 1'b0;
      end
      if (enter_done) begin
        tag_hi_q    <= pair_hi;
        tag_lo_q    <= pair_lo;
        tag_valid_q <= 1'b1;
      end
    end
  end
`else
  assign fuse_hit = 1'b0;
  assign fuse_hi  = '0;
  assign fuse_lo  = '0;
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed plus randomized checks of muldiv_seq against an
// arithmetic reference model, with a scoreboard fed by the driver and drained
// by an independent response monitor.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int XLEN = 32;
  localparam logic [2:0] T_MUL = 3'b000, T_MULH = 3'b001, T_MULHSU = 3'b010, T_MULHU = 3'b011;
  localparam logic [2:0] T_DIV = 3'b100, T_DIVU = 3'b101, T_REM = 3'b110, T_REMU = 3'b111;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_a, req_b;
  logic            flush;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_result;
  logic            busy;
  state_e          dbg_state;

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .flush       (flush),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- scoreboard ----------------
  logic [XLEN-1:0] exp_q[$];
  int unsigned     due_q[$];   // cycle index at which resp_valid must first be seen
  int              bp_next = 0;
  int              resp_cnt = 0;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] xa, xb, p;
    bit a_s, b_s;
    int ia, ib;
    a_s = (op == T_MUL) || (op == T_MULH) || (op == T_MULHSU);
    b_s = (op == T_MUL) || (op == T_MULH);
    xa  = a_s ? {{32{a[31]}}, a} : {32'd0, a};
    xb  = b_s ? {{32{b[31]}}, b} : {32'd0, b};
    p   = xa * xb;
    ia  = a;
    ib  = b;
    case (op)
      T_MUL:                    return p[31:0];
      T_MULH, T_MULHSU, T_MULHU: return p[63:32];
      T_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      T_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      T_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return ((op == T_DIV) || (op == T_REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // Reuse model: last completed {a, b, signedness class, mul/div}.
  bit          m_valid = 1'b0;
  logic [31:0] m_a, m_b;
  int          m_cls;
  bit          m_div;

  function automatic int cls_of(input logic [2:0] op);
    if (op == T_MUL || op == T_MULH || op == T_DIV || op == T_REM) return 0;
    if (op == T_MULHSU) return 1;
    return 2;
  endfunction

  function automatic bit model_hit(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FUSE_EN
    return m_valid && m_a == a && m_b == b && m_cls == cls_of(op) && m_div == op[2];
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_set(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    m_valid = 1'b1; m_a = a; m_b = b; m_cls = cls_of(op); m_div = op[2];
  endtask

  // ---------------- driver tasks ----------------
  task automatic accept_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output bit ok, output int unsigned e0);
    int waited = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    while (!req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    ok = req_ready;
    e0 = 0;
    if (!ok) begin
      checks++;
      $display("FAIL req_ready_timeout: got ready=0 after 200 cycles required ready=1");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    e0 = cyc;
    req_valid = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int bp);
    bit ok;
    int unsigned e0;
    int unsigned d;
    logic [31:0] exp;
    exp = ref_result(op, a, b);
    d = (is_special(op, a, b) || model_hit(op, a, b)) ? 0 : XLEN + 1;
    bp_next = bp;
    accept_req(op, a, b, ok, e0);
    if (ok) begin
      exp_q.push_back(exp);
      due_q.push_back(e0 + d);
      model_set(op, a, b);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || resp_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    m_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- monitor ----------------
  initial begin
    bit          in_resp = 1'b0;
    int          hold = 0;
    logic [31:0] cur = '0;
    int unsigned due;
    resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        in_resp = 1'b0;
        resp_ready = 1'b0;
      end else if (resp_valid) begin
        if (!in_resp) begin
          in_resp = 1'b1;
          hold = bp_next;
          bp_next = 0;
          resp_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_resp: got resp_valid=1 result 0x%08h required no response", resp_result);
          end else begin
            cur = exp_q.pop_front();
            due = due_q.pop_front();
            check("result", resp_result, cur);
            check("latency_cycle", cyc, due);
          end
        end else begin
          check("hold_result", resp_result, cur);
          check("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        if (hold > 0) begin
          resp_ready = 1'b0;
          hold--;
        end else begin
          resp_ready = 1'b1;
        end
      end else begin
        in_resp = 1'b0;
        resp_ready = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit          ok;
    int unsigned e0;
    int          rc;
    logic [2:0]  op;
    logic [31:0] a, b, pa, pb;

    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_resp_result", resp_result, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // multiply sign handling
    run_op(T_MUL,   32'd7, 32'hFFFF_FFFD, 0);
    run_op(T_MULH,  32'd7, 32'hFFFF_FFFD, 0);
    run_op(T_MULHU, 32'd7, 32'hFFFF_FFFD, 0);
    run_op(T_MULHSU, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 0);
    // divide sign handling
    run_op(T_DIV,  32'hFFFF_FFEC, 32'd3, 0);
    run_op(T_REM,  32'hFFFF_FFEC, 32'd3, 0);
    run_op(T_DIVU, 32'd20, 32'd3, 0);
    run_op(T_REMU, 32'd20, 32'd3, 0);
    // special cases
    run_op(T_DIV,  32'd5, 32'd0, 0);
    run_op(T_REMU, 32'd5, 32'd0, 0);
    run_op(T_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(T_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0);
    drain();

    // flush 10 cycles into a DIV
    rc = resp_cnt;
    accept_req(T_DIV, 32'd1000, 32'd7, ok, e0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    m_valid = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("flush_no_resp", resp_cnt, rc);
    run_op(T_MUL, 32'd3, 32'd4, 0);
    drain();

    // flush beats a same-cycle request
    @(negedge clk);
    req_valid = 1'b1; req_op = T_MUL; req_a = 32'd9; req_b = 32'd9; flush = 1'b1;
    #1;
    check("flush_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    m_valid = 1'b0;
    #1;
    check("flush_no_accept", {31'd0, busy}, 32'd0);

    // backpressure, then a following accept
    run_op(T_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 5);
    run_op(T_DIVU, 32'hDEAD_BEEF, 32'h1234, 0);
    drain();

    // result reuse, then the same pair separated by a flush
    run_op(T_DIV, 32'd100, 32'd7, 0);
    run_op(T_REM, 32'd100, 32'd7, 0);
    drain();
    run_op(T_DIV, 32'd100, 32'd7, 0);
    drain();
    do_flush();
    run_op(T_REM, 32'd100, 32'd7, 0);
    drain();

    // reset in the middle of a multiply
    accept_req(T_MUL, 32'd11, 32'd13, ok, e0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_valid = 1'b0;
    run_op(T_MUL, 32'd11, 32'd13, 0);

    // randomized operations, sometimes repeating operands
    pa = 32'd1; pb = 32'd1;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        a = pa; b = pb;
      end else begin
        a = rand_val(); b = rand_val();
      end
      run_op(op, a, b, $urandom_range(0, 2));
      pa = a; pb = b;
    end
    drain();
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
